// File: rtl/dwt_lift_step_pkg.sv
// Shared types, coefficients and saturating add
// for the 9/7 DWT lifting datapath.
package dwt_pkg;

    localparam int WIDTH = 16;
    localparam int POINT = 10;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t even;
        sample_t odd;
        logic    last;
    } pair_t;

    typedef enum logic [1:0] {
        EMPTY,
        PEND,
        FLUSH
    } lift_state_e;

    localparam sample_t LIFT_ALPHA = -16'sd1624;
    localparam sample_t LIFT_BETA  = -16'sd54;
    localparam sample_t LIFT_GAMMA = 16'sd904;
    localparam sample_t LIFT_DELTA = 16'sd454;

    // Overflow shows up as the two top bits of the 17-bit sum differing.
    function automatic sample_t sat_add(
        input sample_t a,
        input sample_t b
    );
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15])
            sat_add = s[16] ? 16'sh8000 : 16'sh7fff;
        else
            sat_add = s[15:0];
    endfunction

endpackage

// File: rtl/dwt_lift_step_if.sv
// Valid/ready pair stream in and out of
// one lifting step.
interface dwt_lift_step_if;
    import dwt_pkg::*;

    logic    in_valid_i;
    logic    in_ready_o;
    sample_t in_even_i;
    sample_t in_odd_i;
    logic    in_last_i;
    logic    out_valid_o;
    logic    out_ready_i;
    sample_t out_even_o;
    sample_t out_odd_o;
    logic    out_last_o;

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_even_i,
        input  in_odd_i,
        input  in_last_i,
        output out_valid_o,
        input  out_ready_i,
        output out_even_o,
        output out_odd_o,
        output out_last_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_even_i,
        output in_odd_i,
        output in_last_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_even_o,
        input  out_odd_o,
        input  out_last_o
    );

endinterface

// File: rtl/dwt_lift_step_mult.sv
// Fixed-point multiplier: floor rounding,
// wraps on overflow (no saturation).
module dwt_lift_step_mult #(
    parameter int Width    = 16,
    parameter int InPoint  = 10,
    parameter int OutPoint = 10
) (
    input  logic signed [Width-1:0] a_i,
    input  logic signed [Width-1:0] b_i,
    output logic signed [Width-1:0] y_o
);

    localparam int Shift = 2 * InPoint - OutPoint;

    logic signed [2*Width-1:0] prod;

    assign prod = a_i * b_i;
    assign y_o  = Width'(prod >>> Shift);

endmodule

// File: rtl/dwt_lift_step.sv
// Streaming lifting step d = odd + K*(even + next_even)
// with one-pair lookahead and mirrored line end.
module dwt_lift_step
    import dwt_pkg::*;
#(
    parameter int Width = 16,
    parameter int Point = 10
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  sample_t         coef_i,
    dwt_lift_step_if.slave  io
);

    if (Width != 16) begin : g_bad_width
        $error("dwt_lift_step: only Width=16 supported");
    end

    lift_state_e state_q, state_d;
    pair_t       p_q;
    pair_t       out_q;
    logic        out_valid_q;

    pair_t   in_pair;
    pair_t   src;
    sample_t nxt;
    sample_t s;
    sample_t m;
    sample_t d;
    logic    take;
    logic    in_ready;
    logic    accept;
    logic    emit;
    logic    load_p;

    assign in_pair = '{io.in_even_i, io.in_odd_i, io.in_last_i};
    assign take    = !out_valid_q || io.out_ready_i;
    assign accept  = io.in_valid_i && in_ready;

    // src.last is the emitted last flag on every path.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        emit     = 1'b0;
        load_p   = 1'b0;
        src      = p_q;
        nxt      = p_q.even;
        unique case (state_q)
            EMPTY: begin
                in_ready = take;
                if (accept) begin
                    if (in_pair.last) begin
                        emit = 1'b1;
                        src  = in_pair;
                        nxt  = in_pair.even;
                    end else begin
                        load_p  = 1'b1;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                in_ready = take;
                if (accept) begin
                    emit   = 1'b1;
                    nxt    = in_pair.even;
                    load_p = 1'b1;
                    if (in_pair.last)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (take) begin
                    emit    = 1'b1;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign s = sat_add(src.even, nxt);

    dwt_lift_step_mult #(
        .Width    (Width),
        .InPoint  (Point),
        .OutPoint (Point)
    ) u_mult (
        .a_i (s),
        .b_i (coef_i),
        .y_o (m)
    );

    assign d = sat_add(src.odd, m);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            p_q <= '0;
        else if (load_p)
            p_q <= in_pair;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (emit) begin
            out_q       <= '{src.even, d, src.last};
            out_valid_q <= 1'b1;
        end else if (take) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.in_ready_o  = in_ready;
    assign io.out_valid_o = out_valid_q;
    assign io.out_even_o  = out_q.even;
    assign io.out_odd_o   = out_q.odd;
    assign io.out_last_o  = out_q.last;

endmodule

// File: tb/tb_dwt_lift_step.sv
// Scoreboard bench for dwt_lift_step: line-level
// reference model, random stalls and data.
module tb_dwt_lift_step;
    import dwt_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    sample_t coef;

    dwt_lift_step_if io();

    dwt_lift_step #(
        .Width (16),
        .Point (10)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .coef_i  (coef),
        .io      (io)
    );

    always #5 clk = ~clk;

    pair_t   exp_q[$];
    int      n_chk = 0;
    int      n_pass = 0;
    int      ready_mode = 0;
    logic    ready_val = 1'b1;
    sample_t le[64];
    sample_t lo[64];
    logic    stall_seen = 1'b0;
    pair_t   held;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic stop_now();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "bench aborted");
    endtask

    function automatic longint clamp(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // d = odd + K*(even+next) in Q.10, straight from the arithmetic rules.
    function automatic sample_t ref_d(
        input sample_t e, input sample_t nx,
        input sample_t o, input sample_t k
    );
        longint  sum;
        longint  prod;
        sample_t m16;
        sum  = clamp(longint'(e) + longint'(nx));
        prod = (sum * longint'(k)) >>> 10;
        m16  = sample_t'(prod);
        return sample_t'(clamp(longint'(o) + longint'(m16)));
    endfunction

    initial begin
        io.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 0)
                io.out_ready_i = ($urandom_range(0, 3) != 0);
            else
                io.out_ready_i = ready_val;
        end
    end

    always @(negedge clk) begin
        pair_t e;
        if (!rst_n) begin
            stall_seen <= 1'b0;
        end else begin
            if (stall_seen) begin
                chk("hold_valid", int'(io.out_valid_o), 1);
                chk("hold_even", int'(io.out_even_o), int'(held.even));
                chk("hold_odd", int'(io.out_odd_o), int'(held.odd));
                chk("hold_last", int'(io.out_last_o), int'(held.last));
            end
            if (io.out_valid_o && io.out_ready_i) begin
                stall_seen <= 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", int'(io.out_odd_o), -99999);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_even", int'(io.out_even_o), int'(e.even));
                    chk("out_odd", int'(io.out_odd_o), int'(e.odd));
                    chk("out_last", int'(io.out_last_o), int'(e.last));
                end
            end else if (io.out_valid_o) begin
                stall_seen <= 1'b1;
                held <= '{io.out_even_o, io.out_odd_o, io.out_last_o};
            end else begin
                stall_seen <= 1'b0;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic drive_pair(input sample_t e, input sample_t o, input logic l);
        int wd;
        io.in_valid_i = 1'b1;
        io.in_even_i  = e;
        io.in_odd_i   = o;
        io.in_last_i  = l;
        wd = 0;
        forever begin
            @(negedge clk);
            if (io.in_ready_o) break;
            wd++;
            if (wd > 300) begin
                chk("in_ready_timeout", 0, 1);
                stop_now();
            end
        end
        @(posedge clk);
        #1;
        io.in_valid_i = 1'b0;
    endtask

    task automatic send_line(input int n, input int gaps);
        pair_t   p;
        sample_t nx;
        for (int i = 0; i < n; i++) begin
            nx = (i + 1 < n) ? le[i+1] : le[i];
            p  = '{le[i], ref_d(le[i], nx, lo[i], coef), (i == n - 1)};
            exp_q.push_back(p);
        end
        for (int i = 0; i < n; i++) begin
            drive_pair(le[i], lo[i], (i == n - 1));
            if (gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain();
        int wd;
        wd = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            wd++;
            if (wd > 500) begin
                chk("drain_timeout", exp_q.size(), 0);
                stop_now();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set3(
        input sample_t e0, input sample_t o0,
        input sample_t e1, input sample_t o1,
        input sample_t e2, input sample_t o2
    );
        le[0] = e0; lo[0] = o0;
        le[1] = e1; lo[1] = o1;
        le[2] = e2; lo[2] = o2;
    endtask

    initial begin
        int n;
        int wd;
        coef          = 16'sd512;
        io.in_valid_i = 1'b0;
        io.in_even_i  = '0;
        io.in_odd_i   = '0;
        io.in_last_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(io.out_valid_o), 0);
        chk("rst_even", int'(io.out_even_o), 0);
        chk("rst_odd", int'(io.out_odd_o), 0);
        chk("rst_last", int'(io.out_last_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(io.in_ready_o), 1);
        @(posedge clk);
        #1;

        set3(1024, 0, 2048, 0, 3072, 0);
        chk("model_t1", int'(ref_d(2048, 3072, 0, 512)), 2560);
        send_line(3, 0);
        wait_drain();

        coef = 16'sd1024;
        le[0] = 1024; lo[0] = 100;
        send_line(1, 0);
        chk("single_valid", int'(io.out_valid_o), 1);
        chk("single_odd", int'(io.out_odd_o), 2148);
        wait_drain();
        @(negedge clk);
        chk("single_empty", int'(io.in_ready_o), 1);
        @(posedge clk);
        #1;

        coef = 16'sd512;
        set3(1024, 0, 2048, 0, 3072, 0);
        fork
            send_line(3, 0);
            begin
                wd = 0;
                do begin
                    @(negedge clk);
                    wd++;
                end while (!io.out_valid_o && wd < 50);
                chk("stall_seen_out", int'(io.out_valid_o), 1);
                ready_val = 1'b0;
                repeat (2) @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(io.in_ready_o), 0);
                    chk("stall_valid", int'(io.out_valid_o), 1);
                end
                ready_val = 1'b1;
            end
        join
        wait_drain();

        coef = 16'sd1024;
        le[0] = 30000; lo[0] = 30000;
        le[1] = 30000; lo[1] = 0;
        chk("model_sat_pos", int'(ref_d(30000, 30000, 30000, 1024)), 32767);
        send_line(2, 0);
        wait_drain();
        le[0] = -30000; lo[0] = -30000;
        le[1] = -30000; lo[1] = 0;
        chk("model_sat_neg", int'(ref_d(-30000, -30000, -30000, 1024)), -32768);
        send_line(2, 0);
        wait_drain();

        coef = LIFT_ALPHA;
        le[0] = 1024; lo[0] = 0;
        le[1] = 1024; lo[1] = 0;
        chk("model_alpha", int'(ref_d(1024, 1024, 0, LIFT_ALPHA)), -3248);
        send_line(2, 0);
        wait_drain();

        // Leave a line half-done with an output parked, then reset.
        coef = 16'sd512;
        ready_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive_pair(500, 7, 1'b0);
        drive_pair(600, 8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(io.out_valid_o), 0);
        chk("arst_odd", int'(io.out_odd_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        le[0] = 100; lo[0] = 10;
        le[1] = 300; lo[1] = 20;
        send_line(2, 0);
        wait_drain();

        ready_mode = 1;
        for (int ln = 0; ln < 30; ln++) begin
            if (ln % 5 == 0) begin
                wait_drain();
                case ($urandom_range(0, 4))
                    0: coef = LIFT_ALPHA;
                    1: coef = LIFT_BETA;
                    2: coef = LIFT_GAMMA;
                    3: coef = LIFT_DELTA;
                    default: coef = sample_t'($urandom);
                endcase
            end
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    le[i] = sample_t'($urandom);
                    lo[i] = sample_t'($urandom);
                end else begin
                    le[i] = sample_t'($urandom_range(0, 4096) - 2048);
                    lo[i] = sample_t'($urandom_range(0, 4096) - 2048);
                end
            end
            send_line(n, 1);
        end
        ready_mode = 0;
        ready_val = 1'b1;
        wait_drain();
        repeat (2) @(negedge clk);
        chk("final_idle", int'(io.out_valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
